fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the program counter and drives the fetch address to the combinational instruction memory.
- Takes the returned instruction and registers it, with its PC and PC+4, into the IF/ID pipeline register for decode.
- Handles sequential fetch, EX-stage branch/jump redirect, hazard-unit stalls and decode flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset or flush.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- PCTargetE  input  32  redirect target from EX (branch/jal/jalr).
- PCSrcE  input  1  1 = redirect PC to PCTargetE.
- StallF  input  1  hold PC register.
- StallD  input  1  hold IF/ID register.
- FlushD  input  1  replace IF/ID contents with a bubble.
- InstrF  input  32  instruction read from memory for address PCF (same-cycle, combinational).
- PCF  output  32  current fetch address, to instruction memory.
- InstrD  output  32  registered instruction for decode.
- PCD  output  32  registered PC of InstrD.
- PCPlus4D  output  32  registered PCD+4.
- ValidD  output  1  1 = InstrD is a real fetched instruction.
- MisalignD  output  1  1 = PCD[1:0] != 0 (instruction-address-misaligned; trap handling is downstream).
- FetchCnt  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (rst=1 at edge) sets:
  - PCF=RESET_PC
  - InstrD=NOP_INSTR
  - PCD=0, PCPlus4D=0
  - ValidD=0, MisalignD=0
  - FetchCnt=0
- Reset has priority over every other input.
- PC next-value priority, highest first:
  - rst
  - PCSrcE=1 -> PCTargetE (redirect overrides StallF)
  - StallF=1 -> hold
  - otherwise PCF+4
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- PCTargetE is loaded unmodified; misaligned targets are fetched and flagged, not corrected.
- IF/ID priority, highest first:
  - rst
  - FlushD=1 -> bubble: InstrD=NOP_INSTR, ValidD=0, MisalignD=0, PCD and PCPlus4D hold (flush overrides StallD)
  - StallD=1 -> all IF/ID outputs hold
  - otherwise capture: InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4, ValidD=1, MisalignD=|PCF[1:0]
- Latency: an instruction at address A is visible on InstrD exactly one cycle after PCF=A, with no stall or flush.
- FetchCnt increments by 1 on each capture (not on flush, stall or reset) and wraps at 2^32.
- Simultaneous PCSrcE=1 and FlushD=1 (taken branch): the PC loads the target and IF/ID gets a bubble in the same edge. The wrong-path instruction fetched that cycle is discarded.
- StallF=1 with StallD=0 is illegal from the hazard unit. The block behaves per the priority rules; no checking is required.
- rst asserted mid-stall or mid-redirect: the next edge gives reset values and any pending redirect is lost.
- While rst=1, the memory returns 0. InstrF is ignored because reset wins.
- No combinational path from any input to PCF; PCF is a pure register output.

Decomposition:
- Shared pipeline package holds:
  - RV32I constants: NOP_INSTR, XLEN=32, RESET_PC default
  - IF/ID bundle typedef: instr, pc, pc_plus4, valid, misalign
- One natural sub-module: if_id_reg (IF/ID register with stall/flush/reset priority), reusable for the ID/EX boundary style.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Sequential fetch: reset, release, memory holding 00500093, 001080b3, 00108133.
  - PCF steps 0,4,8.
  - Cycle after each: InstrD=00500093, 001080b3, 00108133; PCD=0,4,8; PCPlus4D=4,8,C; ValidD=1; FetchCnt=1,2,3.
- Redirect plus flush: at PCF=0x1C, assert PCSrcE=1, PCTargetE=0x18, FlushD=1.
  - Next edge: PCF=0x18, InstrD=00000013, ValidD=0, FetchCnt unchanged.
  - Following edge: PCD=0x18.
- Stall: StallF=StallD=1 for 3 cycles at PCF=0x10.
  - PCF stays 0x10; InstrD, PCD, FetchCnt frozen.
  - After release: PCD=0x10, then 0x14.
- Priority: StallF=1, StallD=1, PCSrcE=1, FlushD=1, PCTargetE=0x20 in one cycle.
  - PCF=0x20; InstrD=NOP, ValidD=0.
- Misaligned and wrap-around:
  - Redirect to 0x22 -> next capture MisalignD=1, PCD=0x22.
  - Redirect to 0xFFFF_FFFC -> PCF wraps to 0 after one step.
- Reset mid-operation: assert rst while PCF=0x14 and StallF=1.
  - Next edge: PCF=0, InstrD=NOP, ValidD=0, FetchCnt=0.
  - Release: fetch resumes at 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared RV32I pipeline definitions: architectural constants and the IF/ID bundle.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            misalign;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline boundary register with reset > flush > stall > capture priority.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_stall,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q.instr    <= BUBBLE_INSTR;
            r_q.pc       <= '0;
            r_q.pc_plus4 <= '0;
            r_q.valid    <= 1'b0;
            r_q.misalign <= 1'b0;
        end else if (i_flush) begin
            // Bubble keeps the old PC fields so debug still sees where the slot came from.
            r_q.instr    <= BUBBLE_INSTR;
            r_q.valid    <= 1'b0;
            r_q.misalign <= 1'b0;
        end else if (!i_stall) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC register, next-PC selection and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCTargetE,
    input  logic        PCSrcE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignD,
    output logic [31:0] FetchCnt
);

    import fetch_stage_pkg::*;

    logic [31:0] r_pc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_capture;
    if_id_t      w_if_d;
    if_id_t      w_if_q;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirect beats stall so a taken branch is never lost behind a hazard hold.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (PCSrcE) begin
            w_pc_next = PCTargetE;
        end else if (StallF) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign w_capture = !FlushD && !StallD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (w_capture) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    always_comb begin
        w_if_d.instr    = InstrF;
        w_if_d.pc       = r_pc;
        w_if_d.pc_plus4 = w_pc_plus4;
        w_if_d.valid    = 1'b1;
        w_if_d.misalign = |r_pc[1:0];
    end

    fetch_stage_if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_stall(StallD),
        .i_flush(FlushD),
        .i_d    (w_if_d),
        .o_q    (w_if_q)
    );

    assign PCF       = r_pc;
    assign InstrD    = w_if_q.instr;
    assign PCD       = w_if_q.pc;
    assign PCPlus4D  = w_if_q.pc_plus4;
    assign ValidD    = w_if_q.valid;
    assign MisalignD = w_if_q.misalign;
    assign FetchCnt  = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] PCTargetE;
    logic        PCSrcE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignD;
    logic [31:0] FetchCnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk      (clk),
        .rst      (rst),
        .PCTargetE(PCTargetE),
        .PCSrcE   (PCSrcE),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
        .MisalignD(MisalignD),
        .FetchCnt (FetchCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three real instructions at 0/4/8, elsewhere a tag derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_80b3;
            32'h0000_0008: mem_word = 32'h0010_8133;
            default:       mem_word = {16'hC0DE, addr[15:0]};
        endcase
    endfunction

    always_comb begin
        InstrF = rst ? 32'h0 : mem_word(PCF);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                            input logic [31:0] pcd, input logic [31:0] p4, input logic valid,
                            input logic mis, input logic [31:0] cnt);
        check({tag, ".PCF"}, PCF, pcf);
        check({tag, ".InstrD"}, InstrD, instr);
        check({tag, ".PCD"}, PCD, pcd);
        check({tag, ".PCPlus4D"}, PCPlus4D, p4);
        check({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, valid});
        check({tag, ".MisalignD"}, {31'b0, MisalignD}, {31'b0, mis});
        check({tag, ".FetchCnt"}, FetchCnt, cnt);
    endtask

    initial begin
        rst = 1'b1;
        PCTargetE = 32'h0;
        PCSrcE = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        step();
        step();
        check_if("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

        // Sequential fetch
        rst = 1'b0;
        step();
        check_if("seq0", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);
        step();
        check_if("seq1", 32'h8, 32'h0010_80b3, 32'h4, 32'h8, 1'b1, 1'b0, 32'd2);
        step();
        check_if("seq2", 32'hC, 32'h0010_8133, 32'h8, 32'hC, 1'b1, 1'b0, 32'd3);
        step();
        check_if("seq3", 32'h10, 32'hC0DE_000C, 32'hC, 32'h10, 1'b1, 1'b0, 32'd4);

        // Stall three cycles at PCF=0x10
        StallF = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if("stall", 32'h10, 32'hC0DE_000C, 32'hC, 32'h10, 1'b1, 1'b0, 32'd4);
        end
        StallF = 1'b0;
        StallD = 1'b0;
        step();
        check_if("unstall0", 32'h14, 32'hC0DE_0010, 32'h10, 32'h14, 1'b1, 1'b0, 32'd5);
        step();
        check_if("unstall1", 32'h18, 32'hC0DE_0014, 32'h14, 32'h18, 1'b1, 1'b0, 32'd6);
        step();
        check_if("seq4", 32'h1C, 32'hC0DE_0018, 32'h18, 32'h1C, 1'b1, 1'b0, 32'd7);

        // Taken branch: redirect plus flush at PCF=0x1C
        PCSrcE = 1'b1;
        PCTargetE = 32'h18;
        FlushD = 1'b1;
        step();
        check_if("redir", 32'h18, NOP, 32'h18, 32'h1C, 1'b0, 1'b0, 32'd7);
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        step();
        check_if("redir_cap", 32'h1C, 32'hC0DE_0018, 32'h18, 32'h1C, 1'b1, 1'b0, 32'd8);

        // All controls at once: redirect beats StallF, flush beats StallD
        StallF = 1'b1;
        StallD = 1'b1;
        PCSrcE = 1'b1;
        FlushD = 1'b1;
        PCTargetE = 32'h20;
        step();
        check_if("prio", 32'h20, NOP, 32'h18, 32'h1C, 1'b0, 1'b0, 32'd8);
        StallF = 1'b0;
        StallD = 1'b0;
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        step();
        check_if("prio_cap", 32'h24, 32'hC0DE_0020, 32'h20, 32'h24, 1'b1, 1'b0, 32'd9);

        // Misaligned target, no flush: wrong-path slot at 0x24 is captured
        PCSrcE = 1'b1;
        PCTargetE = 32'h22;
        step();
        check_if("mis_redir", 32'h22, 32'hC0DE_0024, 32'h24, 32'h28, 1'b1, 1'b0, 32'd10);
        PCSrcE = 1'b0;
        step();
        check_if("mis_cap", 32'h26, 32'hC0DE_0022, 32'h22, 32'h26, 1'b1, 1'b1, 32'd11);

        // Wrap-around from the top of the address space
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        step();
        check_if("wrap_redir", 32'hFFFF_FFFC, 32'hC0DE_0026, 32'h26, 32'h2A, 1'b1, 1'b1, 32'd12);
        PCSrcE = 1'b0;
        step();
        check_if("wrap", 32'h0, 32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 32'd13);

        // Run up to PCF=0x14 then reset in the middle of a stall and redirect
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("pre_rst.PCF", PCF, 32'h14);
        check("pre_rst.FetchCnt", FetchCnt, 32'd18);
        rst = 1'b1;
        StallF = 1'b1;
        StallD = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h40;
        step();
        check_if("mid_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        PCSrcE = 1'b0;
        step();
        check_if("resume", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
